// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the Hi/Lo sequencing unit.
//   - state_e      : FSM encoding (IDLE/ISSUE/WAIT)
//   - OP_DIV/OP_MULT: operation select encoding carried on OpSel
//   - *_DEF        : default unit latencies, also used by the control-unit
//                    stall logic so both sides agree on operation length.
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_MULT = 1'b1;

  localparam int DIV_LAT_DEF  = 32;
  localparam int MULT_LAT_DEF = 33;
  localparam int CNT_W_DEF    = 6;

endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: latency counter for one div/mult operation.
// Ports:
//   clk     in  system clock
//   rst_i   in  synchronous active-high reset (count -> 0)
//   load_i  in  load the count with 1 (edge where the unit samples its start)
//   inc_i   in  increment the count; never moves past the selected latency
//   op_i    in  selects which latency to compare against (OP_DIV/OP_MULT)
//   cnt_o   out current count
//   hit_o   out count equals the selected latency
module hilo_lat_counter
  import hilo_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             op_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_sel;

  assign lat_sel = (op_i == OP_MULT) ? MULT_LAT_C : DIV_LAT_C;
  assign hit_o   = (cnt_q == lat_sel);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_ONE;
    end else if (inc_i && !hit_o) begin
      // Saturating: the count stops at the selected latency.
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: sequences one divide or multiply, captures the 64-bit result
// into the architectural Hi/Lo registers, serves mthi/mtlo and reports
// divide-by-zero.
// Ports:
//   clk, Reset              clock, synchronous active-high reset
//   Start, OpSel            operation request (0=div, 1=mult), IDLE only
//   MtHi, MtLo, MtData      mthi/mtlo writes, IDLE only
//   DivHiFio/DivLoFio       divider remainder/quotient, DivZero flag
//   MultHi/MultLo           multiplier product halves
//   DivControl/MultControl  one-cycle start pulse to the selected unit
//   Hi, Lo                  architectural registers (to mfhi/mflo)
//   Busy                    state != IDLE; control unit stalls on it
//   Done                    one-cycle pulse in the cycle after capture
//   DivZeroExc              one-cycle pulse on divide-by-zero abort
// Handshake: Start is a request, accepted on any edge where Busy is low;
// there is no backpressure. Completion is signalled by exactly one of Done
// or DivZeroExc (none if Reset aborts the operation).
// The FSM state is held in state_q for observation.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        OpSel,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] MtData,
  input  logic [31:0] DivHiFio,
  input  logic [31:0] DivLoFio,
  input  logic        DivZero,
  input  logic [31:0] MultHi,
  input  logic [31:0] MultLo,
  output logic        DivControl,
  output logic        MultControl,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZeroExc
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        div_ctl_q, div_ctl_d;
  logic        mult_ctl_q, mult_ctl_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic             cnt_load, cnt_inc, cnt_hit;
  logic [CNT_W-1:0] cnt;

  hilo_lat_counter #(
    .CNT_W    (CNT_W),
    .DIV_LAT  (DIV_LAT),
    .MULT_LAT (MULT_LAT)
  ) u_cnt (
    .clk    (clk),
    .rst_i  (Reset),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .op_i   (op_q),
    .cnt_o  (cnt),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_ctl_d  = 1'b0;
    mult_ctl_d = 1'b0;
    done_d     = 1'b0;
    dz_d       = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Mt writes and Start may coincide; the later capture wins.
        if (MtHi) hi_d = MtData;
        if (MtLo) lo_d = MtData;
        if (Start) begin
          op_d       = OpSel;
          div_ctl_d  = (OpSel == OP_DIV);
          mult_ctl_d = (OpSel == OP_MULT);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The unit samples its control pulse on this edge.
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Divide-by-zero is only looked at one edge after issue.
        if (op_q == OP_DIV && cnt == CNT_ONE && DivZero) begin
          dz_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_hit) begin
          if (op_q == OP_MULT) begin
            hi_d = MultHi;
            lo_d = MultLo;
          end else begin
            hi_d = DivHiFio;
            lo_d = DivLoFio;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_DIV;
      hi_q       <= '0;
      lo_q       <= '0;
      div_ctl_q  <= 1'b0;
      mult_ctl_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_ctl_q  <= div_ctl_d;
      mult_ctl_q <= mult_ctl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign DivControl  = div_ctl_q;
  assign MultControl = mult_ctl_q;
  assign Hi          = hi_q;
  assign Lo          = lo_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign DivZeroExc  = dz_q;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Downstream consumer of the sequential divider and the multiplier.
- Sequences one div or mult operation: issues the one-cycle start pulse, counts the unit's fixed latency, and captures the 64-bit result into architectural Hi/Lo registers.
- Reports divide-by-zero to the control unit.
- Serves mthi/mtlo writes; Hi/Lo outputs feed the mfhi/mflo path.

Parameters:
- DIV_LAT, 32, number of clock edges from the divider sampling DivControl to its Hi/Lo outputs being valid.
- MULT_LAT, 33, same definition for the multiplier's MultControl.
- CNT_W, 6, width of the latency counter; must hold max(DIV_LAT, MULT_LAT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  control unit requests an operation; sampled only in IDLE.
- OpSel  in  1  0 = divide, 1 = multiply; sampled with Start.
- MtHi  in  1  write MtData into Hi (mthi).
- MtLo  in  1  write MtData into Lo (mtlo).
- MtData  in  32  mthi/mtlo write data.
- DivHiFio  in  32  divider remainder.
- DivLoFio  in  32  divider quotient.
- DivZero  in  1  divider divide-by-zero flag.
- MultHi  in  32  multiplier upper product.
- MultLo  in  32  multiplier lower product.
- DivControl  out  1  one-cycle start pulse to the divider.
- MultControl  out  1  one-cycle start pulse to the multiplier.
- Hi  out  32  architectural Hi register.
- Lo  out  32  architectural Lo register.
- Busy  out  1  high whenever state != IDLE; control unit stalls mfhi/mflo/mthi/mtlo/div/mult while high.
- Done  out  1  one-cycle pulse, high in the cycle after Hi/Lo capture.
- DivZeroExc  out  1  one-cycle pulse on a divide-by-zero abort.

Behaviour:
- Reset (sync, highest priority): state=IDLE, counter=0, Hi=0, Lo=0, DivControl=0, MultControl=0, Done=0, DivZeroExc=0. Mid-operation Reset aborts with no capture and no pulses; a late unit result is ignored.
- All outputs are registered. Done, DivZeroExc, DivControl and MultControl default to 0 every edge unless set below.
- States: IDLE, ISSUE, WAIT.
- IDLE: at edge E0 with Start=1:
  - latch OpSel into op_r;
  - set DivControl (op_r=0) or MultControl (op_r=1) high for exactly the next cycle;
  - go to ISSUE.
- IDLE with MtHi/MtLo: Hi<=MtData and/or Lo<=MtData. Both may be asserted together.
- IDLE, Start and Mt* on the same edge: the Mt write takes effect AND the operation starts. The capture later overwrites Hi/Lo.
- ISSUE, edge E1: the unit samples its control. Counter<=1, go to WAIT.
- WAIT, edge E1+j (counter==j before the edge):
  - If op_r=div, j==1 and DivZero==1: go to IDLE, DivZeroExc=1 next cycle, Hi/Lo unchanged, no Done.
  - Else if counter==LAT (DIV_LAT or MULT_LAT per op_r): capture Hi/Lo from the selected unit (div: Hi<=DivHiFio, Lo<=DivLoFio; mult: Hi<=MultHi, Lo<=MultLo), Done=1 next cycle, go to IDLE.
  - Else counter<=counter+1.
- Latency: Start accepted at E0 gives Hi/Lo updated at edge E0+LAT+1 and Done high in the following cycle. With DIV_LAT=32, capture is at E33.
- Start, MtHi and MtLo are ignored while Busy.
- Capture with no Reset: the selected unit outputs are taken verbatim, no sign manipulation.
- Counter saturation: the counter never exceeds LAT. LAT values of 0 are illegal; LAT=1 means capture at E2.
- Back-to-back: Start high on the same cycle Done is high is accepted, because state is IDLE at that edge.

Decomposition:
- Shared package hilo_pkg holds:
  - state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10);
  - OP_DIV=1'b0 and OP_MULT=1'b1;
  - default DIV_LAT/MULT_LAT constants, shared with the control-unit stall logic.
- One natural sub-module: hilo_lat_counter. It provides load-to-1, increment, and an equality compare against the selected latency, outputting a hit signal.
- Hi/Lo registers and the FSM stay in hilo_unit.

Test Plan:
- Reset, then idle: Hi=0, Lo=0, Busy=0, Done=0, DivZeroExc=0, both control pulses 0.
- Divide 100/7 with a divider model: Start, OpSel=0 at E0. Required: DivControl high exactly one cycle; Busy high from E0+1 to E33; Hi=2, Lo=14 after E33; Done pulse in cycle 34.
- Divide with DivZero=1 asserted at E2: DivZeroExc one-cycle pulse, Busy low after E2, Hi/Lo keep prior values (preset 0xAAAA5555 / 0x12345678), no Done.
- Multiply 0xFFFFFFFF * 2 (signed -2) with a MULT_LAT=33 model: Hi=0xFFFFFFFF, Lo=0xFFFFFFFE after E34; MultControl pulse only, DivControl stays 0.
- mthi 0xDEADBEEF in IDLE gives Hi=0xDEADBEEF. MtLo asserted while Busy: Lo unchanged. Start during Busy: no second control pulse.
- Reset at E10 of a divide: state IDLE, Hi=Lo=0, no Done. A new Start at E12 completes normally, capturing at E12+33.
